// File: rtl/gate_signature_compactor.sv
// gate_signature_compactor
// Folds a stream of gate-model response vectors into a MISR and, after a
// programmed number of vectors, compares the final signature against a
// golden value to grade a netlist without storing every output vector.
//
// Optional build macro: GSC_ABORT_EN
//   When defined, an `abort` input is added. Asserting it while a run is
//   active returns to IDLE with signature and count held for inspection.

module gate_signature_compactor #(
    parameter int unsigned       RESP_W = 10,
    parameter int unsigned       SIG_W  = 16,
    parameter int unsigned       CNT_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
    parameter logic [SIG_W-1:0]  SEED   = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
`ifdef GSC_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vectors,
    input  logic [SIG_W-1:0]  golden,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One MISR step: shift left, apply feedback taps when the MSB falls
    // out, then inject the zero-extended response vector.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0]  sig,
        input logic [RESP_W-1:0] data
    );
        logic [SIG_W-1:0] ext;
        logic [SIG_W-1:0] fb;
        ext              = '0;
        ext[RESP_W-1:0]  = data;
        fb               = sig[SIG_W-1] ? POLY : '0;
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ ext;
    endfunction

    state_e           state_q,  state_d;
    logic [SIG_W-1:0] sig_q,    sig_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] nv_q,     nv_d;
    logic [SIG_W-1:0] gold_q,   gold_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             pass_q,   pass_d;
    logic             ready_q,  ready_d;

    logic             hs_s;
    logic             abort_s;
    logic [SIG_W-1:0] sig_next_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // Handshake, abort qualification and the candidate next MISR/count values.
    always_comb begin
        hs_s       = ready_q & resp_valid;
`ifdef GSC_ABORT_EN
        abort_s    = abort & (state_q == ST_RUN);
`else
        abort_s    = 1'b0;
`endif
        sig_next_s = misr_step(sig_q, resp_data);
        cnt_inc_s  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Next-state and registered-output decode for the run controller.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        nv_d    = nv_q;
        gold_d  = gold_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    nv_d   = num_vectors;
                    gold_d = golden;
                    sig_d  = SEED;
                    cnt_d  = '0;
                    if (num_vectors != '0) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        // Empty run: the signature is the seed itself.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (SEED == golden);
                        ready_d = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    // Signature and count are deliberately left untouched.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    ready_d = 1'b0;
                end else if (hs_s) begin
                    sig_d = sig_next_s;
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == nv_q) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_next_s == gold_q);
                        ready_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sig_d   = SEED;
                cnt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            nv_q    <= '0;
            gold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            nv_q    <= nv_d;
            gold_q  <= gold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            ready_q <= ready_d;
        end
    end

    assign resp_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign count      = cnt_q;

endmodule

// File: tb/tb_gate_signature_compactor.sv
// Testbench for gate_signature_compactor: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
// Two instances share inputs; the second uses SEED=16'h8000.

module tb_gate_signature_compactor;

`ifdef GSC_ABORT_EN
    localparam bit AB = 1'b1;
`else
    localparam bit AB = 1'b0;
`endif
    localparam int POLY  = 32'h1021;
    localparam int SEED1 = 32'h0000;
    localparam int SEED2 = 32'h8000;

    logic        clk = 1'b0;
    logic        rst, start, resp_valid, abort_i;
    logic [15:0] num_vectors, golden;
    logic [9:0]  resp_data;
    logic        ready1, busy1, done1, pass1;
    logic        ready2, busy2, done2, pass2;
    logic [15:0] sig1, cnt1, sig2, cnt2;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_mode;          // 0 idle, 1 run, 2 done
    int m_sig1, m_sig2, m_cnt, m_nv, m_gold;
    bit m_busy, m_done, m_pass1, m_pass2;

    always #5 clk = ~clk;

    gate_signature_compactor u_dut1 (
        .clk(clk), .rst(rst),
`ifdef GSC_ABORT_EN
        .abort(abort_i),
`endif
        .start(start), .num_vectors(num_vectors), .golden(golden),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(ready1),
        .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .count(cnt1)
    );

    gate_signature_compactor #(.SEED(16'h8000)) u_dut2 (
        .clk(clk), .rst(rst),
`ifdef GSC_ABORT_EN
        .abort(abort_i),
`endif
        .start(start), .num_vectors(num_vectors), .golden(golden),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(ready2),
        .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .count(cnt2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Polynomial division step over GF(2): multiply by x, reduce modulo
    // x^16 + POLY, then add the response vector.
    function automatic int fold(input int s, input int d);
        int t;
        t = s * 2;
        if (t >= 65536) t = (t - 65536) ^ POLY;
        return t ^ d;
    endfunction

    task automatic model_update();
        if (rst) begin
            m_mode = 0; m_sig1 = SEED1; m_sig2 = SEED2; m_cnt = 0;
            m_busy = 0; m_done = 0; m_pass1 = 0; m_pass2 = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_nv = num_vectors; m_gold = golden;
                m_sig1 = SEED1; m_sig2 = SEED2; m_cnt = 0;
                if (num_vectors != 0) begin
                    m_mode = 1; m_busy = 1; m_done = 0; m_pass1 = 0; m_pass2 = 0;
                end else begin
                    m_mode = 2; m_busy = 0; m_done = 1;
                    m_pass1 = (SEED1 == m_gold); m_pass2 = (SEED2 == m_gold);
                end
            end
        end else begin
            if (AB && abort_i) begin
                m_mode = 0; m_busy = 0; m_done = 0; m_pass1 = 0; m_pass2 = 0;
            end else if (resp_valid) begin
                m_sig1 = fold(m_sig1, resp_data);
                m_sig2 = fold(m_sig2, resp_data);
                m_cnt++;
                if (m_cnt == m_nv) begin
                    m_mode = 2; m_busy = 0; m_done = 1;
                    m_pass1 = (m_sig1 == m_gold); m_pass2 = (m_sig2 == m_gold);
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("sig1",  sig1,   m_sig1);
        check_eq("sig2",  sig2,   m_sig2);
        check_eq("count", cnt1,   m_cnt);
        check_eq("busy",  busy1,  m_busy);
        check_eq("done",  done1,  m_done);
        check_eq("pass1", pass1,  m_pass1);
        check_eq("pass2", pass2,  m_pass2);
        check_eq("ready", ready1, (m_mode == 1));
        check_eq("ready2", ready2, ready1);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit r, input bit s, input int nv, input int g,
                         input bit v, input int d, input bit a);
        rst = r; start = s; num_vectors = nv[15:0]; golden = g[15:0];
        resp_valid = v; resp_data = d[9:0]; abort_i = a;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        tick();
        idle_cycle();
        // 1: single vector, pass
        drive(1'b0, 1'b1, 1, 32'h0155, 1'b0, 0, 1'b0); tick();
        drive(1'b0, 1'b0, 0, 0, 1'b1, 32'h155, 1'b0); tick();
        check_eq("t1_sig", sig1, 32'h0155);
        check_eq("t1_pass", pass1, 1);
        // valid held high after completion is not consumed
        tick();
        check_eq("t1_hold_cnt", cnt1, 1);
        // 2: two vectors with a 3-cycle gap
        drive(1'b0, 1'b1, 2, 32'h02AB, 1'b0, 0, 1'b0); tick();
        drive(1'b0, 1'b0, 0, 0, 1'b1, 32'h155, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            check_eq("t2_gap_sig", sig1, 32'h0155);
        end
        drive(1'b0, 1'b0, 0, 0, 1'b1, 32'h001, 1'b0); tick();
        check_eq("t2_sig", sig1, 32'h02AB);
        check_eq("t2_pass", pass1, 1);
        // 3: SEED=8000 instance, zero data
        drive(1'b0, 1'b1, 1, 0, 1'b0, 0, 1'b0); tick();
        drive(1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b0); tick();
        check_eq("t3_sig2", sig2, 32'h1021);
        check_eq("t3_pass2", pass2, 0);
        check_eq("t3_done2", done2, 1);
        // 4: zero-length run
        drive(1'b0, 1'b1, 0, SEED1, 1'b1, 32'h3FF, 1'b0); tick();
        check_eq("t4_done", done1, 1);
        check_eq("t4_pass", pass1, 1);
        drive(1'b0, 1'b0, 0, 0, 1'b1, 32'h3FF, 1'b0); tick();
        check_eq("t4_ready", ready1, 0);
        // 5: reset mid-run, then restart; start in RUN ignored
        drive(1'b0, 1'b1, 4, 0, 1'b0, 0, 1'b0); tick();
        drive(1'b0, 1'b1, 1, 0, 1'b1, 32'h2A5, 1'b0); tick();
        drive(1'b0, 1'b0, 0, 0, 1'b1, 32'h15A, 1'b0); tick();
        check_eq("t5_cnt2", cnt1, 2);
        drive(1'b1, 1'b1, 1, 0, 1'b1, 32'h001, 1'b0); tick();
        check_eq("t5_rst_sig", sig1, SEED1);
        check_eq("t5_rst_ready", ready1, 0);
        drive(1'b0, 1'b1, 2, 0, 1'b0, 0, 1'b0); tick();
        drive(1'b0, 1'b0, 0, 0, 1'b1, 32'h0F0, 1'b0); tick();
        check_eq("t5_restart_sig", sig1, 32'h00F0);
        if (AB) begin
            // 6: abort after two handshakes
            drive(1'b0, 1'b0, 0, 0, 1'b1, 32'h00F, 1'b0); tick();
            drive(1'b0, 1'b1, 4, 0, 1'b0, 0, 1'b0); tick();
            drive(1'b0, 1'b0, 0, 0, 1'b1, 32'h111, 1'b0); tick();
            drive(1'b0, 1'b0, 0, 0, 1'b1, 32'h222, 1'b0); tick();
            drive(1'b0, 1'b0, 0, 0, 1'b1, 32'h333, 1'b1); tick();
            check_eq("t6_abort_cnt", cnt1, 2);
            check_eq("t6_abort_done", done1, 0);
        end
        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                  $urandom_range(6), $urandom_range(65535),
                  ($urandom_range(9) < 7), $urandom_range(1023),
                  ($urandom_range(15) == 0));
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
